// File: rtl/cmd_arbiter_if.sv
// Radio command bus shared by the Pi SPI path (port 0), the local FPGA requester (port 1)
// and the slaves; master is the arbiter's view, slave is the requester/slave side.
interface cmd_arbiter_if;
   logic        s0_valid;
   logic        s0_ready;
   logic [5:0]  s0_addr;
   logic [31:0] s0_data;
   logic        s0_ptt;
   logic        s1_valid;
   logic        s1_ready;
   logic [5:0]  s1_addr;
   logic [31:0] s1_data;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_ptt;
   logic        cmd_rqst;
   logic        cmd_src;
   logic        cmd_ack;

   modport master (
      input  s0_valid, s0_addr, s0_data, s0_ptt,
      input  s1_valid, s1_addr, s1_data,
      output s0_ready, s1_ready,
      output cmd_addr, cmd_data, cmd_ptt, cmd_rqst, cmd_src,
      input  cmd_ack
   );

   modport slave (
      output s0_valid, s0_addr, s0_data, s0_ptt,
      output s1_valid, s1_addr, s1_data,
      input  s0_ready, s1_ready,
      input  cmd_addr, cmd_data, cmd_ptt, cmd_rqst, cmd_src,
      output cmd_ack
   );
endinterface

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter for the radio command bus: one command in flight, ack wait with
// timeout, then a forced idle gap before the next grant.
module cmd_arbiter #(
   parameter int unsigned ACK_TIMEOUT = 64,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   cmd_arbiter_if.master bus,
   output logic          busy,
   output logic          err_timeout,
   output logic [7:0]    err_count
);

   localparam int unsigned CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
   localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_GAP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          last_grant;
   logic          grant;
   logic          accept;
   logic          timeout;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant     = 1'b0;
      accept    = 1'b0;
      timeout   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.s0_valid || bus.s1_valid) begin
               accept    = 1'b1;
               grant     = (bus.s0_valid && bus.s1_valid) ? ~last_grant : bus.s1_valid;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ACK_TIMEOUT != 0) begin
               state_nxt = ST_WAIT_ACK;
               cnt_nxt   = CNT_ONE;
            end else if (GAP_CYCLES != 0) begin
               state_nxt = ST_GAP;
               cnt_nxt   = CNT_ONE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_ACK: begin
            // An ack on the terminal count wins over the timeout.
            if (bus.cmd_ack || cnt == ACK_LAST) begin
               timeout = ~bus.cmd_ack;
               if (GAP_CYCLES != 0) begin
                  state_nxt = ST_GAP;
                  cnt_nxt   = CNT_ONE;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.s0_ready = accept & ~grant;
   assign bus.s1_ready = accept & grant;
   assign busy         = (state != ST_IDLE);
   assign err_timeout  = timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         last_grant   <= 1'b1;
         bus.cmd_addr <= '0;
         bus.cmd_data <= '0;
         bus.cmd_ptt  <= 1'b0;
         bus.cmd_src  <= 1'b0;
         bus.cmd_rqst <= 1'b0;
         err_count    <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         // Registered so the pulse crossing into the slave synchronisers is glitch-free.
         bus.cmd_rqst <= (state_nxt == ST_ISSUE);
         if (accept) begin
            last_grant  <= grant;
            bus.cmd_src <= grant;
            if (grant) begin
               bus.cmd_addr <= bus.s1_addr;
               bus.cmd_data <= bus.s1_data;
            end else begin
               bus.cmd_addr <= bus.s0_addr;
               bus.cmd_data <= bus.s0_data;
               bus.cmd_ptt  <= bus.s0_ptt;
            end
         end
         if (timeout && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Randomised scoreboard bench for cmd_arbiter: a cycle-level reference model predicts grants,
// busy/timeout timing and the command each cmd_rqst must carry.
module tb_cmd_arbiter;
   localparam int ACK = 64;
   localparam int GAP = 4;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      logic        ptt;
      logic        src;
      int          acc;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy, err_timeout, f_busy, f_err;
   logic [7:0] err_count, f_cnt;

   cmd_arbiter_if bus ();
   cmd_arbiter_if fbus ();

   cmd_arbiter #(.ACK_TIMEOUT(ACK), .GAP_CYCLES(GAP)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .busy(busy), .err_timeout(err_timeout), .err_count(err_count));

   cmd_arbiter #(.ACK_TIMEOUT(0), .GAP_CYCLES(0)) u_fast (
      .clk(clk), .rst_n(rst_n), .bus(fbus),
      .busy(f_busy), .err_timeout(f_err), .err_count(f_cnt));

   always #5 clk = ~clk;

   int    checks = 0, failures = 0, cyc = 0;
   item_t sb[$], fq[$];
   item_t mon_e, fe;
   int    acc_src[$];

   logic        p_valid [2];
   logic [5:0]  p_addr  [2];
   logic [31:0] p_data  [2];
   logic        p_ptt;
   logic        m_last = 1'b1, m_ptt = 1'b0;
   int          m_cnt = 0, tout_total = 0;
   int          free_cyc = 0, ack_cyc = -1, to_cyc = -1, w_lo = 1, w_hi = 0;
   bit          gen_en = 0, stray_en = 0, drop_en = 0, fast_done = 0;
   int          gen_div = 1, fixed_d = -1;

   int   fc = 0, ffree = 0, facc = -100, fg = 0, frefresh = -1;
   logic flast = 1'b1, fptt = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic new_cmd(input int p);
      p_valid[p] = 1'b1;
      p_addr[p]  = 6'($urandom);
      p_data[p]  = $urandom;
      if (p == 0) p_ptt = 1'($urandom);
   endtask

   task automatic pick_d(output int d);
      int r;
      if (fixed_d >= 0) d = fixed_d;
      else begin
         r = $urandom_range(0, 9);
         if (r < 7)       d = $urandom_range(1, 6);
         else if (r == 7) d = ACK;
         else             d = ACK + 5;
      end
   endtask

   // One clock cycle: drive, sample, compare, then advance the reference model.
   task automatic cycle();
      int d, k, g;
      bit acc, ack;
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
         if (gen_en && !p_valid[p] && ($urandom % gen_div) == 0) new_cmd(p);
         else if (drop_en && p_valid[p] && cyc < free_cyc && ($urandom % 40) == 0) p_valid[p] = 1'b0;
      end
      bus.s0_valid = p_valid[0]; bus.s0_addr = p_addr[0]; bus.s0_data = p_data[0]; bus.s0_ptt = p_ptt;
      bus.s1_valid = p_valid[1]; bus.s1_addr = p_addr[1]; bus.s1_data = p_data[1];
      ack = (cyc == ack_cyc);
      if (stray_en && !(cyc >= w_lo && cyc <= w_hi) && ($urandom % 6) == 0) ack = 1'b1;
      bus.cmd_ack = ack;
      #1;
      acc = 0; g = 0;
      if (cyc >= free_cyc && (p_valid[0] || p_valid[1])) begin
         acc = 1;
         g = (p_valid[0] && p_valid[1]) ? int'(!m_last) : (p_valid[1] ? 1 : 0);
      end
      chk("busy", busy, cyc < free_cyc);
      chk("s0_ready", bus.s0_ready, acc && g == 0);
      chk("s1_ready", bus.s1_ready, acc && g == 1);
      chk("err_timeout", err_timeout, cyc == to_cyc);
      chk("err_count", err_count, m_cnt);
      if (cyc == to_cyc) begin
         if (m_cnt < 255) m_cnt++;
         tout_total++;
      end
      if (acc) begin
         m_last = g[0];
         if (g == 0) m_ptt = p_ptt;
         sb.push_back('{p_addr[g], p_data[g], m_ptt, g[0], cyc});
         acc_src.push_back(g);
         p_valid[g] = 1'b0;
         pick_d(d);
         k = (d > ACK) ? ACK : d;
         free_cyc = cyc + 2 + k + GAP;
         w_lo = cyc + 2;
         w_hi = cyc + 1 + k;
         ack_cyc = (d <= ACK) ? cyc + 1 + d : -1;
         to_cyc  = (d > ACK) ? cyc + 1 + ACK : -1;
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_cmd_addr"}, bus.cmd_addr, 0);
      chk({tag, "_cmd_data"}, bus.cmd_data, 0);
      chk({tag, "_cmd_ptt"}, bus.cmd_ptt, 0);
      chk({tag, "_cmd_rqst"}, bus.cmd_rqst, 0);
      chk({tag, "_cmd_src"}, bus.cmd_src, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
      chk({tag, "_err_count"}, err_count, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && cyc < free_cyc + 2; i++) cycle();
   endtask

   // Scoreboard monitor: every cmd_rqst pulse must match the oldest accepted command.
   always @(negedge clk) begin
      #2;
      if (rst_n && bus.cmd_rqst) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL rqst_unexpected: got cmd_rqst=1 expected 0 (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            chk("rqst_timing", cyc, mon_e.acc + 1);
            chk("cmd_addr", bus.cmd_addr, mon_e.addr);
            chk("cmd_data", bus.cmd_data, mon_e.data);
            chk("cmd_ptt", bus.cmd_ptt, mon_e.ptt);
            chk("cmd_src", bus.cmd_src, mon_e.src);
         end
      end
   end

   // Fire-and-forget, no-gap instance: both ports held valid, grants every second cycle.
   initial begin
      fbus.s0_valid = 1'b0; fbus.s1_valid = 1'b0; fbus.cmd_ack = 1'b0;
      fbus.s0_addr = '0; fbus.s0_data = '0; fbus.s0_ptt = 1'b0;
      fbus.s1_addr = '0; fbus.s1_data = '0;
      wait (rst_n);
      fbus.s0_valid = 1'b1; fbus.s1_valid = 1'b1;
      fbus.s0_addr = 6'($urandom); fbus.s0_data = $urandom; fbus.s0_ptt = 1'($urandom);
      fbus.s1_addr = 6'($urandom); fbus.s1_data = $urandom;
      repeat (40) begin
         @(negedge clk);
         fc++;
         if (frefresh == 0) begin
            fbus.s0_addr = 6'($urandom); fbus.s0_data = $urandom; fbus.s0_ptt = 1'($urandom);
         end else if (frefresh == 1) begin
            fbus.s1_addr = 6'($urandom); fbus.s1_data = $urandom;
         end
         frefresh = -1;
         fbus.cmd_ack = 1'($urandom);
         #1;
         chk("f_rqst", fbus.cmd_rqst, fc == facc + 1);
         chk("f_busy", f_busy, fc == facc + 1);
         chk("f_err", {f_err, f_cnt}, 0);
         if (fbus.cmd_rqst && fq.size() > 0) begin
            fe = fq.pop_front();
            chk("f_cmd_addr", fbus.cmd_addr, fe.addr);
            chk("f_cmd_data", fbus.cmd_data, fe.data);
            chk("f_cmd_ptt", fbus.cmd_ptt, fe.ptt);
            chk("f_cmd_src", fbus.cmd_src, fe.src);
         end
         if (fc >= ffree) begin
            fg = int'(!flast);
            chk("f_s0_ready", fbus.s0_ready, fg == 0);
            chk("f_s1_ready", fbus.s1_ready, fg == 1);
            if (fg == 0) begin
               fptt = fbus.s0_ptt;
               fq.push_back('{fbus.s0_addr, fbus.s0_data, fptt, 1'b0, fc});
            end else begin
               fq.push_back('{fbus.s1_addr, fbus.s1_data, fptt, 1'b1, fc});
            end
            flast = fg[0]; ffree = fc + 2; facc = fc; frefresh = fg;
         end else begin
            chk("f_readys_idle", {fbus.s0_ready, fbus.s1_ready}, 0);
         end
      end
      fast_done = 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      p_valid[0] = 1'b0; p_valid[1] = 1'b0;
      p_addr[0] = '0; p_addr[1] = '0; p_data[0] = '0; p_data[1] = '0; p_ptt = 1'b0;
      bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; bus.cmd_ack = 1'b0;
      bus.s0_addr = '0; bus.s0_data = '0; bus.s0_ptt = 1'b0;
      bus.s1_addr = '0; bus.s1_data = '0;
      #1;
      reset_checks("rst");
      #6 rst_n = 1'b1;

      // Tie from reset: s0 first, then strict alternation; s1 command must not touch PTT.
      p_addr[0] = 6'h0A; p_data[0] = 32'h12345678; p_ptt = 1'b1; p_valid[0] = 1'b1;
      p_addr[1] = 6'h3B; p_data[1] = $urandom; p_valid[1] = 1'b1;
      gen_en = 1; gen_div = 1; fixed_d = 3;
      for (int i = 0; i < 200 && acc_src.size() < 4; i++) cycle();
      chk("tie_count", acc_src.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("tie_order", (i < acc_src.size()) ? acc_src[i] : -1, i % 2);
      gen_en = 0;
      drain();

      // Random traffic with ack jitter, terminal-cycle acks, timeouts, stray acks, withdrawn requests.
      gen_en = 1; gen_div = 3; fixed_d = -1; stray_en = 1; drop_en = 1;
      repeat (3000) cycle();
      gen_en = 0; stray_en = 0; drop_en = 0;
      p_valid[0] = 1'b0; p_valid[1] = 1'b0;
      drain();

      // Reset while waiting for an ack, with s1 pending; s1 must be served after reset.
      fixed_d = ACK + 10;
      new_cmd(0);
      begin
         int n0;
         n0 = acc_src.size();
         for (int i = 0; i < 20 && acc_src.size() == n0; i++) cycle();
      end
      p_valid[1] = 1'b1; p_addr[1] = 6'h3B; p_data[1] = $urandom;
      repeat (3) cycle();
      #2 rst_n = 1'b0;
      #1;
      reset_checks("midrst");
      m_last = 1'b1; m_ptt = 1'b0; m_cnt = 0; free_cyc = 0;
      ack_cyc = -1; to_cyc = -1; w_lo = 1; w_hi = 0;
      sb.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      fixed_d = 2;
      begin
         int n1;
         n1 = acc_src.size();
         for (int i = 0; i < 20 && acc_src.size() == n1; i++) cycle();
         chk("s1_served_after_reset", acc_src.size(), n1 + 1);
      end
      drain();

      // 300 consecutive timeouts: err_count saturates at 255.
      fixed_d = ACK + 1; gen_en = 1; gen_div = 1; tout_total = 0;
      for (int i = 0; i < 30000 && tout_total < 300; i++) cycle();
      chk("timeouts_seen", tout_total, 300);
      chk("err_count_sat", err_count, 255);
      gen_en = 0;
      p_valid[0] = 1'b0; p_valid[1] = 1'b0;
      drain();

      for (int i = 0; i < 100 && !fast_done; i++) @(negedge clk);
      chk("fast_done", fast_done, 1);
      chk("sb_empty", sb.size(), 0);
      chk("f_sb_empty", fq.size() > 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
